aes_req_arbiter: RTL and testbench

- Shares one multicycle aes_128 core between NUM_REQ requesters.
- Round-robin grant; each granted block is tagged with the requester id.
- Each completed ciphertext goes into a 2-entry response FIFO with a valid/ready output.
- Sits between the client ports and the core. It launches blocks only when the core is ready and only when response space is guaranteed.

---
 rtl/aes_req_arbiter.sv | 124 ++++++++++++
 tb/tb_aes_req_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_arbiter.sv
// Round-robin front end that shares one multicycle AES-128 core between NUM_REQ
// requesters; launches only when a response slot is reserved in a 2-entry FIFO.
module aes_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic [127:0]           core_in_bus,
  output logic [127:0]           core_key,
  input  logic [127:0]           core_out_bus,
  input  logic                   core_valid_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [ID_W-1:0]        rsp_id
);
  localparam int ENT_W = ID_W + 128;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_q;
  logic [ID_W-1:0]   inflight_id_q;
  logic [ENT_W-1:0]  mem_q [2];
  logic [ENT_W-1:0]  mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [ENT_W-1:0]  head_d;
  logic              rsp_valid_q;
  logic [127:0]      rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;

  logic              pop_s, capture_s, credit_s, grant_s;
  logic              gnt_found_s;
  logic [ID_W-1:0]   gnt_id_s, cand_s;
  logic [127:0]      data_a [NUM_REQ];
  logic [127:0]      key_a  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_a[i] = req_data[128*i +: 128];
    assign key_a[i]  = req_key[128*i +: 128];
  end

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  // Round-robin search: first valid requester after the last one granted.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_id_s    = '0;
    cand_s      = next_id(rr_q);
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt_id_s    = (!gnt_found_s && req_valid[cand_s]) ? cand_s : gnt_id_s;
      gnt_found_s = gnt_found_s | req_valid[cand_s];
      cand_s      = next_id(cand_s);
    end
  end

  // Credit check and launch mux; a pop this cycle frees a slot for a new launch.
  always_comb begin
    pop_s       = rsp_valid_q & rsp_ready;
    capture_s   = core_valid_ready & (state_q == BUSY);
    credit_s    = ({1'b0, count_q} + {2'b00, (state_q == BUSY)}) < (3'd2 + {2'b00, pop_s});
    grant_s     = ~rst & core_valid_ready & gnt_found_s & credit_s;
    req_ready   = grant_s ? (NUM_REQ'(1) << gnt_id_s) : '0;
    core_in_bus = grant_s ? data_a[gnt_id_s] : 128'h0;
    core_key    = grant_s ? key_a[gnt_id_s] : 128'h0;
  end

  // Response FIFO next state; the output register tracks the post-update head.
  always_comb begin
    mem_d           = mem_q;
    mem_d[wr_ptr_q] = capture_s ? {inflight_id_q, core_out_bus} : mem_q[wr_ptr_q];
    wr_ptr_d        = wr_ptr_q ^ capture_s;
    rd_ptr_d        = rd_ptr_q ^ pop_s;
    count_d         = count_q + {1'b0, capture_s} - {1'b0, pop_s};
    head_d          = (count_d != 2'd0) ? mem_d[rd_ptr_d] : '0;
  end

  // Arbiter FSM, FIFO storage and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_q          <= ID_W'(NUM_REQ - 1);
      inflight_id_q <= '0;
      mem_q[0]      <= '0;
      mem_q[1]      <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 128'h0;
      rsp_id_q      <= '0;
    end else begin
      if (core_valid_ready) begin
        state_q <= grant_s ? BUSY : IDLE;
      end
      if (grant_s) begin
        rr_q          <= gnt_id_s;
        inflight_id_q <= gnt_id_s;
      end
      mem_q[0]    <= mem_d[0];
      mem_q[1]    <= mem_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= (count_d != 2'd0);
      rsp_data_q  <= head_d[127:0];
      rsp_id_q    <= head_d[ENT_W-1 -: ID_W];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: behavioural AES-128 core, queue-based reference
// model of grants/credits/responses, directed scenarios plus random traffic.
module tb_aes_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int P       = 11;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_data;
  logic [NUM_REQ*128-1:0] req_key;
  logic [127:0]           core_in_bus, core_key, core_out_bus;
  logic                   core_valid_ready;
  logic                   rsp_valid, rsp_ready;
  logic [127:0]           rsp_data;
  logic [ID_W-1:0]        rsp_id;

  aes_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key),
    .core_in_bus(core_in_bus), .core_key(core_key),
    .core_out_bus(core_out_bus), .core_valid_ready(core_valid_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] ct;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox(s[4*(((i/4) + (i%4)) % 4) + (i%4)]);
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  // Core model: ready every P cycles, result of a launch appears at the next one
  int           core_cnt;
  logic [127:0] core_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cnt <= 0;
      core_res <= 128'h0;
    end else begin
      if (core_valid_ready) core_res <= aes128(core_in_bus, core_key);
      core_cnt <= (core_cnt == P - 1) ? 0 : core_cnt + 1;
    end
  end
  assign core_valid_ready = (core_cnt == P - 1);
  assign core_out_bus     = core_res;

  always @(posedge clk)
    if (!rst) assert (!(dut.capture_s && dut.count_q == 2'd2))
      else $error("capture into a full response FIFO");

  int n_check = 0;
  int n_fail  = 0;
  logic [129:0] m_infl [$];
  logic [129:0] m_fifo [$];
  int           m_rr = NUM_REQ - 1;
  int           grants [$];
  logic [129:0] pops [$];
  int           idle_rv = 0;
  int           triple  = 0;
  logic [NUM_REQ-1:0] hold;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_check++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    int g, avail;
    bit pop, cap;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [127:0] exp_in, exp_key;
    forever begin
      @(negedge clk);
      if (rst) begin
        check_eq("rst_req_ready", 128'(req_ready), 128'h0);
        check_eq("rst_rsp_valid", 128'(rsp_valid), 128'h0);
        check_eq("rst_rsp_data", rsp_data, 128'h0);
        check_eq("rst_rsp_id", 128'(rsp_id), 128'h0);
        check_eq("rst_core_in", core_in_bus, 128'h0);
        check_eq("rst_core_key", core_key, 128'h0);
        m_infl.delete();
        m_fifo.delete();
        m_rr = NUM_REQ - 1;
      end else begin
        check_eq("rsp_valid", 128'(rsp_valid), 128'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
          check_eq("rsp_data", rsp_data, m_fifo[0][127:0]);
          check_eq("rsp_id", 128'(rsp_id), 128'(m_fifo[0][129:128]));
        end
        if (rsp_valid) idle_rv++;
        pop   = (m_fifo.size() != 0) && rsp_ready;
        cap   = core_valid_ready && (m_infl.size() != 0);
        avail = 2 - m_fifo.size() - m_infl.size() + (pop ? 1 : 0);
        g = -1;
        if (core_valid_ready && avail >= 1) begin
          for (int k = 1; k <= NUM_REQ; k++) begin
            if (g < 0 && req_valid[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
          end
        end
        exp_rdy = '0;
        exp_in  = 128'h0;
        exp_key = 128'h0;
        if (g >= 0) begin
          exp_rdy[g] = 1'b1;
          exp_in     = req_data[128*g +: 128];
          exp_key    = req_key[128*g +: 128];
        end
        check_eq("req_ready", 128'(req_ready), 128'(exp_rdy));
        check_eq("core_in_bus", core_in_bus, exp_in);
        check_eq("core_key", core_key, exp_key);
        if (core_valid_ready && rsp_valid && rsp_ready && req_ready != '0 && m_infl.size() == 1)
          triple++;
        if (rsp_valid && rsp_ready) pops.push_back({rsp_id, rsp_data});
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grants.push_back(i);
        if (pop) void'(m_fifo.pop_front());
        if (cap) m_fifo.push_back(m_infl.pop_front());
        if (g >= 0) begin
          m_infl.push_back({2'(g), aes128(exp_in, exp_key)});
          m_rr = g;
        end
      end
    end
  endtask

  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        if (hold[i]) new_block(i);
        else req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic new_block(input int i);
    req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
    req_key[128*i +: 128]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (grants.size() < n && c < budget) begin
      tick();
      c++;
    end
    check_eq(tag, 128'(grants.size() >= n), 128'h1);
  endtask

  task automatic wait_ready(input int budget);
    int c;
    c = 0;
    while (!core_valid_ready && c < budget) begin
      tick();
      c++;
    end
    check_eq("ready_timeout", 128'(core_valid_ready), 128'h1);
  endtask

  task automatic quiesce();
    hold      = '0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (40) tick();
  endtask

  initial begin
    int base, c;
    fork
      monitor();
    join_none
    rst = 1'b0; req_valid = '0; req_data = '0; req_key = '0; rsp_ready = 1'b0; hold = '0;
    #1;
    do_reset();

    // FIPS-197 appendix C.1 vector through requester 0
    rsp_ready = 1'b1;
    base = pops.size();
    req_data[127:0] = 128'h00112233445566778899aabbccddeeff;
    req_key[127:0]  = 128'h000102030405060708090a0b0c0d0e0f;
    req_valid[0]    = 1'b1;
    c = 0;
    while (pops.size() <= base && c < 80) begin tick(); c++; end
    repeat (30) tick();
    check_eq("fips_count", 128'(pops.size() - base), 128'h1);
    if (pops.size() > base) begin
      check_eq("fips_data", pops[base][127:0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check_eq("fips_id", 128'(pops[base][129:128]), 128'h0);
    end

    // Round robin from a fresh reset
    do_reset();
    rsp_ready = 1'b1;
    base = grants.size();
    hold = '1;
    for (int i = 0; i < NUM_REQ; i++) new_block(i);
    req_valid = '1;
    wait_grants(base + 6, 200, "rr_timeout");
    for (int k = 0; k < 6; k++)
      if (grants.size() > base + k) check_eq("rr_order", 128'(grants[base + k]), 128'(k % 4));
    quiesce();

    // Backpressure: two grants fill the FIFO, one pop admits exactly one more
    rsp_ready = 1'b0;
    base = grants.size();
    hold[1] = 1'b1; hold[2] = 1'b1;
    new_block(1); new_block(2);
    req_valid[1] = 1'b1; req_valid[2] = 1'b1;
    repeat (60) tick();
    check_eq("bp_grants", 128'(grants.size() - base), 128'h2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (12) tick();
    check_eq("bp_regrant", 128'(grants.size() - base), 128'h3);
    repeat (30) tick();
    check_eq("bp_hold", 128'(grants.size() - base), 128'h3);
    quiesce();

    // Pop, capture and launch on the same ready cycle
    rsp_ready = 1'b0;
    base = grants.size();
    hold[3] = 1'b1;
    new_block(3);
    req_valid[3] = 1'b1;
    wait_grants(base + 2, 40, "sim_timeout");
    tick();
    wait_ready(20);
    triple    = 0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("sim_triple", 128'(triple), 128'h1);
    check_eq("sim_grants", 128'(grants.size() - base), 128'h3);
    quiesce();

    // Reset with one response queued and one block in flight
    rsp_ready = 1'b0;
    base = grants.size();
    new_block(1); new_block(2);
    req_valid[1] = 1'b1; req_valid[2] = 1'b1;
    wait_grants(base + 2, 40, "rmf_timeout");
    repeat (5) tick();
    check_eq("rmf_pre_valid", 128'(rsp_valid), 128'h1);
    rst = 1'b1;
    #1;
    check_eq("rmf_req_ready", 128'(req_ready), 128'h0);
    check_eq("rmf_rsp_valid", 128'(rsp_valid), 128'h0);
    check_eq("rmf_rsp_data", rsp_data, 128'h0);
    check_eq("rmf_rsp_id", 128'(rsp_id), 128'h0);
    check_eq("rmf_core_in", core_in_bus, 128'h0);
    check_eq("rmf_core_key", core_key, 128'h0);
    repeat (2) tick();
    rst = 1'b0;

    // Idle: nothing requested for 50 cycles
    rsp_ready = 1'b1;
    idle_rv = 0;
    repeat (50) tick();
    check_eq("idle_no_rsp", 128'(idle_rv), 128'h0);

    // Random traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      tick();
      rsp_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(7) == 0) begin
            new_block(i);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(63) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    quiesce();
    check_eq("drain_empty", 128'(rsp_valid), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_check, n_fail);
    $finish;
  end

endmodule
